// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game blocks: sequence builder state encoding
// and default sequence geometry, reused by the game controller.
package simon_pkg;

  localparam int SIMON_DEPTH  = 16;
  localparam int SIMON_SYM_W  = 2;
  localparam int SIMON_ADDR_W = 4;

  typedef enum logic [1:0] {
    SB_IDLE   = 2'd0,
    SB_FILL   = 2'd1,
    SB_APPEND = 2'd2,
    SB_FINISH = 2'd3
  } sb_state_e;

endpackage

// File: rtl/sequence_builder.sv
// Builds the Simon pad sequence in external memory: bulk FILL from address 0
// or APPEND one symbol, drawing each symbol from an external LFSR.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// SB_IDLE   | waiting for start; mode/len_req sampled here only
// SB_FILL   | writing count LFSR symbols from address 0
// SB_APPEND | writing one LFSR symbol at seq_len (zero writes when full)
// SB_FINISH | one-cycle done pulse; seq_len takes its new value here
module sequence_builder
  import simon_pkg::*;
#(
  parameter int DEPTH  = SIMON_DEPTH,
  parameter int SYM_W  = SIMON_SYM_W,
  parameter int ADDR_W = SIMON_ADDR_W
) (
  input  logic              clk_tick,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W:0]   len_req,
  input  logic [SYM_W-1:0]  lfsr_val,
  output logic              lfsr_enable,
  output logic              write_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [SYM_W-1:0]  wr_data,
  output logic [ADDR_W:0]   seq_len,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  sb_state_e         state_q, state_d;
  logic [ADDR_W:0]   base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   seq_len_q, seq_len_d;
  logic              ovf_q, ovf_d;
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [SYM_W-1:0]  wr_data_q, wr_data_d;

  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset) begin
      state_q    <= SB_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      seq_len_q  <= '0;
      ovf_q      <= 1'b0;
      write_en_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      seq_len_q  <= seq_len_d;
      ovf_q      <= ovf_d;
      write_en_q <= write_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    idx_d       = idx_q;
    seq_len_d   = seq_len_q;
    ovf_d       = ovf_q;
    write_en_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    lfsr_enable = 1'b0;

    unique case (state_q)
      SB_IDLE: begin
        if (start) begin
          idx_d = '0;
          if (mode) begin
            // A rejected APPEND runs with zero writes so done/overflow share FINISH.
            base_d  = seq_len_q;
            count_d = full ? '0 : ONE_L;
            ovf_d   = full;
            state_d = SB_APPEND;
          end else begin
            base_d  = '0;
            count_d = (len_req > DEPTH_L) ? DEPTH_L : len_req;
            ovf_d   = 1'b0;
            state_d = SB_FILL;
          end
        end
      end

      SB_FILL, SB_APPEND: begin
        if (idx_q < count_q) begin
          lfsr_enable = 1'b1;
          write_en_d  = 1'b1;
          wr_addr_d   = ADDR_W'(base_q + idx_q);
          wr_data_d   = lfsr_val;
          idx_d       = idx_q + ONE_L;
        end else begin
          seq_len_d = base_q + count_q;
          state_d   = SB_FINISH;
        end
      end

      SB_FINISH: begin
        state_d = SB_IDLE;
      end

      default: begin
        state_d = SB_IDLE;
      end
    endcase
  end

  assign write_en = write_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign seq_len  = seq_len_q;
  assign busy     = (state_q != SB_IDLE);
  assign done     = (state_q == SB_FINISH);
  assign overflow = (state_q == SB_FINISH) && ovf_q;
  assign full     = (seq_len_q == DEPTH_L);

endmodule

// File: tb/tb_sequence_builder.sv
// Randomized bench for sequence_builder: each operation's expected write
// schedule, status pulses and seq_len are derived from the operation rules.
module tb_sequence_builder;

  localparam int DEPTH  = 16;
  localparam int SYM_W  = 2;
  localparam int ADDR_W = 4;
  localparam int HN     = 4096;

  logic              clk_tick = 1'b0;
  logic              reset;
  logic              start;
  logic              mode;
  logic [ADDR_W:0]   len_req;
  logic [SYM_W-1:0]  lfsr_val;
  logic              lfsr_enable;
  logic              write_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [SYM_W-1:0]  wr_data;
  logic [ADDR_W:0]   seq_len;
  logic              busy;
  logic              done;
  logic              full;
  logic              overflow;

  sequence_builder #(.DEPTH(DEPTH), .SYM_W(SYM_W), .ADDR_W(ADDR_W)) dut (
    .clk_tick    (clk_tick),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .len_req     (len_req),
    .lfsr_val    (lfsr_val),
    .lfsr_enable (lfsr_enable),
    .write_en    (write_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .seq_len     (seq_len),
    .busy        (busy),
    .done        (done),
    .full        (full),
    .overflow    (overflow)
  );

  always #5 clk_tick = ~clk_tick;

  // Edge counter and the LFSR value present at every rising edge.
  int               cyc = 0;
  logic [SYM_W-1:0] hist [HN];

  always @(posedge clk_tick) begin
    cyc <= cyc + 1;
    hist[(cyc + 1) % HN] <= lfsr_val;
  end

  always @(negedge clk_tick) lfsr_val = SYM_W'($urandom);

  int n_vec = 0;
  int n_err = 0;

  // Reference state: stored length and last write-port contents.
  int sl_model   = 0;
  int last_addr  = 0;
  int last_data  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; start is sampled at the next edge (E0).
  task automatic run_op(input logic m, input int len, input bit hold);
    int  base, cnt, new_sl, e0, exp_sl;
    bit  ovf;
    base   = m ? sl_model : 0;
    ovf    = m && (sl_model == DEPTH);
    cnt    = m ? (ovf ? 0 : 1) : ((len > DEPTH) ? DEPTH : len);
    new_sl = base + cnt;

    start   = 1'b1;
    mode    = m;
    len_req = (ADDR_W+1)'(len);
    @(negedge clk_tick);
    e0 = cyc;
    if (!hold) start = 1'b0;
    mode    = 1'($urandom);
    len_req = (ADDR_W+1)'($urandom);

    for (int k = 0; k <= cnt + 2; k++) begin
      if (k > 0) @(negedge clk_tick);
      if (hold && k == cnt + 1) start = 1'b0;
      exp_sl = (k >= cnt + 1) ? new_sl : sl_model;
      chk("write_en", write_en, 32'(k >= 1 && k <= cnt));
      if (k >= 1 && k <= cnt) begin
        last_addr = base + k - 1;
        last_data = int'(hist[(e0 + k) % HN]);
      end
      chk("wr_addr", wr_addr, last_addr);
      chk("wr_data", wr_data, last_data);
      chk("lfsr_enable", lfsr_enable, 32'(k < cnt));
      chk("busy", busy, 32'(k <= cnt + 1));
      chk("done", done, 32'(k == cnt + 1));
      chk("overflow", overflow, 32'(k == cnt + 1 && ovf));
      chk("seq_len", seq_len, exp_sl);
      chk("full", full, 32'(exp_sl == DEPTH));
    end
    sl_model = new_sl;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_write_en"}, write_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_seq_len"}, seq_len, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_lfsr_enable"}, lfsr_enable, 0);
    chk({tag, "_full"}, full, 0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    len_req  = '0;
    lfsr_val = '0;
    repeat (2) @(negedge clk_tick);
    chk_all_zero("rst");
    reset = 1'b0;

    // Fill 10, then append up to full, then one rejected append.
    run_op(1'b0, 10, 1'b0);
    repeat (6) run_op(1'b1, 0, 1'b0);
    run_op(1'b1, 0, 1'b0);
    run_op(1'b0, 0, 1'b0);
    run_op(1'b0, 31, 1'b0);

    // Reset after the 4th write of a fill of 10.
    start   = 1'b1;
    mode    = 1'b0;
    len_req = 5'd10;
    @(negedge clk_tick);
    start = 1'b0;
    repeat (4) @(negedge clk_tick);
    chk("pre_rst_write_en", write_en, 1);
    chk("pre_rst_wr_addr", wr_addr, 3);
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    repeat (2) begin
      @(negedge clk_tick);
      chk("rst_hold_write_en", write_en, 0);
      chk("rst_hold_busy", busy, 0);
    end
    reset     = 1'b0;
    sl_model  = 0;
    last_addr = 0;
    last_data = 0;
    run_op(1'b0, 3, 1'b0);

    // Start held through a fill of 3, then a fresh fill right after done.
    run_op(1'b0, 3, 1'b1);
    run_op(1'b0, 5, 1'b0);

    repeat (24) begin
      logic m;
      int   len;
      bit   h;
      m   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(0, 31));
      h   = 1'($urandom_range(0, 1));
      run_op(m, len, h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sequence_builder.md
SEQUENCE_BUILDER -- requirements
Module: sequence_builder

Interface
REQ-001 Parameter DEPTH, default 16, maximum sequence length (symbols stored).
REQ-002 Parameter SYM_W, default 2, symbol width (2 bits = 4 pad colours).
REQ-003 Parameter ADDR_W, default 4, write-address width; DEPTH SHALL be no greater than 2**ADDR_W.
REQ-004 clk_tick  in  1  clock; reset  in  1  asynchronous, active-high.
REQ-005 start  in  1  operation request, sampled only in IDLE.
REQ-006 mode  in  1  0 = bulk FILL from address 0, 1 = APPEND one symbol at end; sampled with start.
REQ-007 len_req  in  ADDR_W+1  FILL symbol count; sampled with start; ignored in APPEND.
REQ-008 lfsr_val  in  SYM_W  random symbol from external LFSR.
REQ-009 lfsr_enable  out  1  advance-LFSR strobe, combinational.
REQ-010 write_en, wr_addr[ADDR_W], wr_data[SYM_W]  out  registered sequence-memory write port.
REQ-011 seq_len  out  ADDR_W+1  count of valid stored symbols.
REQ-012 busy  out  1 operation in progress; done  out  1 one-cycle completion pulse.
REQ-013 full  out  1  seq_len == DEPTH; overflow  out  1  one-cycle pulse on rejected APPEND.

Function
REQ-014 States SHALL be IDLE, FILL, APPEND, FINISH; encoded state register.
REQ-015 IDLE + start=1 at edge E0 SHALL latch base (0 for FILL, seq_len for APPEND) and count (min(len_req, DEPTH) for FILL, 1 for APPEND), then enter FILL or APPEND.
REQ-016 In FILL/APPEND, while idx < count: lfsr_enable=1 combinationally, and the next edge SHALL register write_en=1, wr_addr=base+idx, wr_data=lfsr_val, then increment idx.
REQ-017 Writes SHALL therefore occur in exactly count consecutive cycles, addresses ascending, first write_en cycle starting 2 edges after E0; each write SHALL carry a distinct LFSR sample.
REQ-018 When idx == count, the state SHALL be FINISH with write_en=0 and lfsr_enable=0; FINISH SHALL last one cycle with done=1 and seq_len=base+count, then return to IDLE.
REQ-019 busy SHALL be 1 from the cycle after E0 through the done cycle inclusive; start SHALL be ignored whenever busy=1.
REQ-020 FILL with len_req=0 SHALL perform no writes, SHALL clear seq_len to 0, and SHALL pulse done at edge E0+2.
REQ-021 FILL with len_req > DEPTH SHALL be clamped to DEPTH writes.
REQ-022 APPEND with full=1 SHALL perform no write and no lfsr_enable, SHALL pulse overflow and done together in the FINISH cycle, and SHALL leave seq_len unchanged.
REQ-023 seq_len SHALL change only in the FINISH cycle; full SHALL be combinational from seq_len.
REQ-024 wr_addr/wr_data SHALL hold their last value when write_en=0.
REQ-025 mode/len_req changes while busy SHALL have no effect.

Reset
REQ-026 reset=1 SHALL immediately force state=IDLE, idx=0, seq_len=0, write_en=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0; lfsr_enable then reads 0.
REQ-027 Reset mid-operation SHALL abort the operation with no further writes; the partially written memory contents are don't-care.
REQ-028 The first start SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-029 State encodings and SYM_W/DEPTH defaults SHALL live in the shared simon_pkg, reused by the game controller.
REQ-030 No sub-module: the LFSR and sequence memory SHALL stay external; the block is a single FSM plus an idx counter.

Verification
REQ-031 Reset, FILL len_req=10 -> 10 writes to addr 0..9, data equal to the lfsr_val sampled at each edge, done at E0+12, seq_len=10.
REQ-032 After REQ-031, APPEND -> one write at addr 10, done pulse, seq_len=11; repeat until seq_len=16 -> full=1.
REQ-033 APPEND with full=1 -> no write_en, overflow=1 and done=1 in the same cycle, seq_len stays 16.
REQ-034 FILL len_req=0 -> no writes, seq_len=0, done at E0+2; FILL len_req=31 -> exactly 16 writes.
REQ-035 Assert reset after the 4th write of a FILL of 10 -> all outputs 0 immediately, no further writes, start accepted at the first edge after release.
REQ-036 start held high through a FILL of 3 -> one operation only; a second FILL starts from IDLE the cycle after done.
